// File: rtl/counter_sequencer_pkg.sv
// Shared encodings for the run-length counter sequencer: FSM states and count direction.
package counter_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage

// File: rtl/counter_sequencer_updown.sv
// Modulo-2^WIDTH up/down counter with a parallel load and a registered
// one-cycle wrap flag.
module updown_counter #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LD,
  input  logic [WIDTH-1:0] LD_VAL,
  input  logic             EN,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             WRAP
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      Q    <= '0;
      WRAP <= 1'b0;
    end else if (LD) begin
      Q    <= LD_VAL;
      WRAP <= 1'b0;
    end else if (EN) begin
      // WRAP marks the cycle in which Q has just crossed the modulus boundary.
      if (UP) begin
        Q    <= Q + ONE;
        WRAP <= (Q == ALL_ONES);
      end else begin
        Q    <= Q - ONE;
        WRAP <= (Q == '0);
      end
    end else begin
      WRAP <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Run-length controller: loads a start value, steps the counter up or down for
// a programmed number of cycles with pause support, and flags completion.
module counter_sequencer
  import counter_sequencer_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int STEPS_W = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               PAUSE,
  input  logic               DIR,
  input  logic [WIDTH-1:0]   LOAD_VAL,
  input  logic [STEPS_W-1:0] STEPS,
  output logic [WIDTH-1:0]   Q,
  output logic               BUSY,
  output logic               DONE,
  output logic               WRAP
);

  localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

  state_t             state;
  logic [STEPS_W-1:0] remaining;
  logic               dir_lat;
  logic               ld;
  logic               en;

  assign ld = (state == IDLE) && START;
  assign en = (state == RUN) && !PAUSE;

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .CLK    (CLK),
    .RST    (RST),
    .LD     (ld),
    .LD_VAL (LOAD_VAL),
    .EN     (en),
    .UP     (dir_lat),
    .Q      (Q),
    .WRAP   (WRAP)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      remaining <= '0;
      dir_lat   <= UP;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          BUSY <= 1'b0;
          if (START) begin
            dir_lat   <= DIR;
            remaining <= STEPS;
            if (STEPS != '0) begin
              state <= RUN;
              BUSY  <= 1'b1;
            end else begin
              state <= FIN;
              DONE  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!PAUSE) begin
            // Saturate at zero so the step counter can never underflow.
            remaining <= (remaining == '0) ? '0 : remaining - STEP_ONE;
            if (remaining <= STEP_ONE) begin
              state <= FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer: each scenario drives a short vector
// sequence and compares {Q,BUSY,DONE,WRAP} one cycle at a time.
module tb_counter_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic       dir;
  logic [2:0] load_val;
  logic [3:0] steps;
  logic [2:0] q;
  logic       busy;
  logic       done;
  logic       wrap;

  int nvec;
  int nfail;

  counter_sequencer #(
    .WIDTH   (3),
    .STEPS_W (4)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .START    (start),
    .PAUSE    (pause),
    .DIR      (dir),
    .LOAD_VAL (load_val),
    .STEPS    (steps),
    .Q        (q),
    .BUSY     (busy),
    .DONE     (done),
    .WRAP     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1; start = 1'b0; pause = 1'b0; dir = 1'b0; load_val = 3'd5; steps = 4'd9;
    tick();
    tick();
    got = {q, busy, done, wrap};
    nvec++;
    if (got !== 6'b000_000) begin
      nfail++;
      $display("FAIL reset: {Q,BUSY,DONE,WRAP}=%b expected %b", got, 6'b000_000);
    end
    rst = 1'b0;
    tick();
    got = {q, busy, done, wrap};
    nvec++;
    if (got !== 6'b000_000) begin
      nfail++;
      $display("FAIL reset_idle: {Q,BUSY,DONE,WRAP}=%b expected %b", got, 6'b000_000);
    end
  endtask

  task automatic test_up_wrap();
    logic [5:0] exp [5];
    logic [5:0] got;
    exp = '{{3'd6, 3'b100}, {3'd7, 3'b100}, {3'd0, 3'b101}, {3'd1, 3'b010}, {3'd1, 3'b000}};
    for (int i = 0; i < 5; i++) begin
      start = (i == 0); dir = 1'b1; load_val = 3'd6; steps = 4'd3; pause = 1'b0;
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL up_wrap cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_down_wrap_done();
    logic [5:0] exp [4];
    logic [5:0] got;
    exp = '{{3'd1, 3'b100}, {3'd0, 3'b100}, {3'd7, 3'b011}, {3'd7, 3'b000}};
    for (int i = 0; i < 4; i++) begin
      start = (i == 0); dir = 1'b0; load_val = 3'd1; steps = 4'd2; pause = 1'b0;
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL down_wrap cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_pause();
    logic [5:0] exp [9];
    logic [5:0] got;
    exp = '{{3'd2, 3'b100}, {3'd3, 3'b100}, {3'd3, 3'b100}, {3'd3, 3'b100}, {3'd3, 3'b100},
            {3'd4, 3'b100}, {3'd5, 3'b100}, {3'd6, 3'b010}, {3'd6, 3'b000}};
    for (int i = 0; i < 9; i++) begin
      start = (i == 0); dir = 1'b1; load_val = 3'd2; steps = 4'd4;
      pause = (i >= 2 && i <= 4);
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL pause cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_zero_steps();
    logic [5:0] exp [3];
    logic [5:0] got;
    exp = '{{3'd5, 3'b010}, {3'd5, 3'b000}, {3'd5, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      start = (i == 0); dir = 1'b1; load_val = 3'd5; steps = 4'd0; pause = 1'b0;
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL zero_steps cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [5:0] exp [6];
    logic [5:0] got;
    exp = '{{3'd3, 3'b100}, {3'd4, 3'b100}, {3'd5, 3'b100}, {3'd6, 3'b010},
            {3'd6, 3'b000}, {3'd6, 3'b000}};
    for (int i = 0; i < 6; i++) begin
      pause = 1'b0;
      if (i == 0) begin
        start = 1'b1; dir = 1'b1; load_val = 3'd3; steps = 4'd3;
      end else begin
        start = (i <= 4); dir = 1'b0; load_val = 3'd0; steps = 4'd7;
      end
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL start_ignored cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [5:0] exp [3];
    logic [5:0] got;
    exp = '{{3'd2, 3'b100}, {3'd3, 3'b100}, {3'd4, 3'b100}};
    for (int i = 0; i < 3; i++) begin
      start = (i == 0); dir = 1'b1; load_val = 3'd2; steps = 4'd4; pause = 1'b0;
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL mid_run cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== 6'b000_000) begin
        nfail++;
        $display("FAIL after_reset cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, 6'b000_000);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp [3];
    logic [5:0] got;
    exp = '{{3'd7, 3'b100}, {3'd0, 3'b011}, {3'd0, 3'b000}};
    for (int i = 0; i < 3; i++) begin
      start = (i == 0); dir = 1'b1; load_val = 3'd7; steps = 4'd1; pause = 1'b0;
      tick();
      got = {q, busy, done, wrap};
      nvec++;
      if (got !== exp[i]) begin
        nfail++;
        $display("FAIL restart cyc%0d: {Q,BUSY,DONE,WRAP}=%b expected %b", i, got, exp[i]);
      end
    end
  endtask

  initial begin
    nvec  = 0;
    nfail = 0;
    test_reset();
    test_up_wrap();
    test_down_wrap_done();
    test_pause();
    test_zero_steps();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
